// File: rtl/nested_struct_arbiter.sv
// Round-robin arbiter with cmd[3] burst locking in front of a registered 62-bit output stage.
// Optional NESTED_ARB_TAG_EN: out_data id[15:12] carries the granted requester index.
module nested_struct_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8,
  parameter int LOCK_TIMEOUT = 16,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*62-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [61:0]             out_data,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [7:0]        burst_q, burst_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              out_valid_q, out_valid_d;
  logic [61:0]       out_data_q, out_data_d;
  logic [IDX_W-1:0]  grant_q, grant_d;

  logic [NUM_REQ-1:0][61:0] req_arr;
  logic                     load_ok;
  logic                     sel_found;
  logic [IDX_W-1:0]         sel_idx;
  logic [IDX_W:0]           cand_w;
  logic [IDX_W-1:0]         cand;
  logic                     xfer;
  logic [61:0]              sel_tx;

  assign req_arr = req_data;
  assign load_ok = !out_valid_q || out_ready;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Requester selection; the decision is recomputed every cycle, never latched.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_w    = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      sel_found = req_valid[owner_q];
      sel_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_w = {1'b0, rr_q} + (IDX_W+1)'(k);
        if (cand_w >= (IDX_W+1)'(NUM_REQ)) cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
        cand = cand_w[IDX_W-1:0];
        if (!sel_found && req_valid[cand]) begin
          sel_found = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  assign xfer      = sel_found && load_ok && !rst;
  assign req_ready = xfer ? (NUM_REQ'(1) << sel_idx) : '0;

  always_comb begin
    sel_tx = req_arr[sel_idx];
`ifdef NESTED_ARB_TAG_EN
    sel_tx[56:53] = 4'(sel_idx);
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_d     = grant_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_tx;
      grant_d     = sel_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          rr_d = wrap_inc(sel_idx);
          if (sel_tx[60] && MAX_BURST > 1) begin
            state_d = LOCKED;
            owner_d = sel_idx;
            burst_d = 8'd1;
            tmo_d   = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_d = burst_q + 8'd1;
          tmo_d   = 8'd0;
          if (!sel_tx[60] || burst_d == 8'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = wrap_inc(owner_q);
          end
        end else if (!req_valid[owner_q]) begin
          // Owner went quiet: count toward releasing the lock.
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == 8'(LOCK_TIMEOUT)) begin
            state_d = IDLE;
            rr_d    = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      burst_q     <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_q     <= grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_nested_struct_arbiter.sv
// Scoreboard bench for nested_struct_arbiter: per-requester source queues, expected grants queued up front.
module tb_nested_struct_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*62-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [61:0]     out_data;
  logic            out_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            locked;

  nested_struct_arbiter #(.NUM_REQ(N), .MAX_BURST(8), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .locked(locked));

  always #5 clk = ~clk;

  typedef struct {
    int          gid;
    logic [61:0] data;
    logic        lk;
  } exp_t;

  logic [61:0] src [N][$];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cyc [N];
  logic        s_out_valid, s_locked;
  logic [61:0] s_out_data;
  logic [N-1:0] s_req_ready;

  function automatic logic [61:0] mk(input logic [3:0] cmd, input int idx, input int seq);
    logic [31:0] d;
    d = $urandom;
    return {1'b1, cmd, 4'hF, 4'(idx), 8'(seq), 8'(seq * 3 + idx), d, 1'b1};
  endfunction

  function automatic logic [61:0] exp_out(input logic [61:0] t, input int g);
    logic [61:0] r;
    r = t;
`ifdef NESTED_ARB_TAG_EN
    r[56:53] = 4'(g);
`endif
    return r;
  endfunction

  task automatic push(input int idx, input logic [61:0] t, input logic lk);
    exp_t e;
    e.gid = idx; e.data = exp_out(t, idx); e.lk = lk;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src[i].size() > 0);
      req_data[i*62 +: 62] = (src[i].size() > 0) ? src[i][0] : 62'h0;
    end
  endtask

  // One clock: observe at negedge (scoreboard pop on output handshake), then retire accepted sources.
  task automatic step();
    logic [N-1:0] acc;
    exp_t e;
    @(negedge clk);
    s_out_valid = out_valid; s_locked = locked; s_out_data = out_data; s_req_ready = req_ready;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got gid=%0d data=%h, expected none", grant_id, out_data);
      end else begin
        e = sb.pop_front();
        if (grant_id !== 2'(e.gid) || out_data !== e.data || locked !== e.lk) begin
          failures++;
          $display("FAIL sb_output: got gid=%0d data=%h locked=%b, expected gid=%0d data=%h locked=%b",
                   grant_id, out_data, locked, e.gid, e.data, e.lk);
        end
      end
    end
    checks++;
    if ($countones(req_ready) > 1) begin
      failures++;
      $display("FAIL ready_onehot: got %b, expected at most one bit", req_ready);
    end
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        acc_cyc[i] = cyc;
        void'(src[i].pop_front());
      end
    drive();
    cyc++;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src[i].delete();
    sb.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid = '1;
    req_data = {N{62'h3FFF_0000_FFFF_1234}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 62'h0 || grant_id !== 2'd0 || locked !== 1'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h g=%0d l=%b rdy=%b, expected all zero",
               out_valid, out_data, grant_id, locked, req_ready);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [61:0] t;
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) begin
        t = mk(4'h0, i, s);
        src[i].push_back(t);
        push(i, t, 1'b0);
      end
    drive();
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first: got out_valid=%b req_ready=%b, expected 0 and 0001", s_out_valid, s_req_ready);
    end
    drain(20, n);
    checks++;
    if (sb.size() != 0 || n != 8) begin
      failures++;
      $display("FAIL rr_throughput: got %0d cycles left=%0d, expected 8 cycles left=0", n, sb.size());
    end
  endtask

  task automatic test_lock_burst();
    int n;
    logic [61:0] t;
    do_reset();
    out_ready = 1'b1;
    t = mk(4'h0, 0, 0); src[0].push_back(t); push(0, t, 1'b0);
    t = mk(4'h0, 1, 0); src[1].push_back(t); push(1, t, 1'b0);
    for (int s = 0; s < 4; s++) begin
      t = mk((s < 3) ? 4'h8 : 4'h0, 2, s);
      src[2].push_back(t);
      push(2, t, s < 3);
    end
    t = mk(4'h0, 3, 0); src[3].push_back(t); push(3, t, 1'b0);
    t = mk(4'h0, 0, 1); src[0].push_back(t); push(0, t, 1'b0);
    t = mk(4'h0, 1, 1); src[1].push_back(t); push(1, t, 1'b0);
    drive();
    drain(30, n);
    checks++;
    if (sb.size() != 0 || n != 10) begin
      failures++;
      $display("FAIL lock_burst_drain: got %0d cycles left=%0d, expected 10 cycles left=0", n, sb.size());
    end
  endtask

  task automatic test_max_burst();
    int n;
    logic [61:0] t;
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      t = mk(4'hF, 1, s);
      src[1].push_back(t);
      if (s == 8) begin
        t = mk(4'h0, 2, 0);
        src[2].push_back(t);
        push(2, t, 1'b0);
        t = src[1][s];
      end
      push(1, t, (s != 7));
    end
    drive();
    drain(30, n);
    checks++;
    if (sb.size() != 0 || n != 12) begin
      failures++;
      $display("FAIL max_burst_drain: got %0d cycles left=%0d, expected 12 cycles left=0", n, sb.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [61:0] t;
    do_reset();
    out_ready = 1'b1;
    t = mk(4'h8, 0, 0); src[0].push_back(t); push(0, t, 1'b1);
    t = mk(4'h0, 3, 0); src[3].push_back(t); push(3, t, 1'b0);
    drive();
    step();
    step();
    checks++;
    if (s_locked !== 1'b1 || s_req_ready !== 4'b0) begin
      failures++;
      $display("FAIL timeout_stall: got locked=%b req_ready=%b, expected 1 and 0000", s_locked, s_req_ready);
    end
    drain(40, n);
    checks++;
    if (sb.size() != 0 || acc_cyc[3] - acc_cyc[0] != 17) begin
      failures++;
      $display("FAIL timeout_gap: got gap=%0d left=%0d, expected gap=17 left=0", acc_cyc[3] - acc_cyc[0], sb.size());
    end
  endtask

  task automatic test_stall();
    int n;
    logic [61:0] a, b;
    do_reset();
    out_ready = 1'b1;
    a = 62'h2AAA_BBBB_CCCC_DDDD;
    b = mk(4'h0, 0, 7);
    src[0].push_back(a); push(0, a, 1'b0);
    src[0].push_back(b); push(0, b, 1'b0);
    drive();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== exp_out(a, 0) || s_req_ready !== 4'b0) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got v=%b d=%h rdy=%b, expected v=1 d=%h rdy=0000",
                 k, s_out_valid, s_out_data, s_req_ready, exp_out(a, 0));
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (s_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL stall_no_bubble: got req_ready=%b, expected 0001", s_req_ready);
    end
    drain(5, n);
    checks++;
    if (sb.size() != 0 || n != 1) begin
      failures++;
      $display("FAIL stall_drain: got %0d cycles left=%0d, expected 1 cycle left=0", n, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [61:0] t;
    do_reset();
    out_ready = 1'b0;
    src[0].push_back(mk(4'h8, 0, 0));
    src[0].push_back(mk(4'h8, 0, 1));
    drive();
    step();
    step();
    checks++;
    if (s_out_valid !== 1'b1 || s_locked !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got out_valid=%b locked=%b, expected 1 and 1", s_out_valid, s_locked);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    out_ready = 1'b1;
    t = mk(4'h0, 0, 2); src[0].push_back(t); push(0, t, 1'b0);
    t = mk(4'h0, 3, 2); src[3].push_back(t); push(3, t, 1'b0);
    drive();
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_locked !== 1'b0 || s_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_after: got v=%b l=%b rdy=%b, expected 0 0 0001", s_out_valid, s_locked, s_req_ready);
    end
    drain(10, n);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL mid_drain: got left=%0d, expected 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_max_burst();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nested_struct_arbiter.md
Name: nested_struct_arbiter

Overview:
- Round-robin arbiter sharing one nested-struct transaction channel among NUM_REQ requesters.
- Each transaction is the 62-bit flattened nested struct:
  - [61] ready
  - [60:57] cmd
  - [56:41] id
  - [40:0] base, which is [40:33] addr, [32:1] data, [0] valid.
- Supports burst locking through cmd[3].
- Registered single-entry output stage with valid/ready handshake; sits upstream of the nested-struct processing datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 8, maximum consecutive locked grants to one owner (1..255).
- LOCK_TIMEOUT, 16, idle cycles in LOCKED before the lock is dropped (1..255).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester transaction valid.
- req_data  input  NUM_REQ*62  requester i occupies bits [i*62+61 : i*62].
- req_ready  output  NUM_REQ  one-hot accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a transaction.
- out_data  output  62  granted transaction.
- out_ready  input  1  downstream accepts out_data.
- grant_id  output  $clog2(NUM_REQ)  index of the requester whose transaction is in out_data.
- locked  output  1  arbiter is in the LOCKED state.

Behaviour:
- Reset values: out_valid=0, out_data=0, grant_id=0, locked=0, req_ready=0. State IDLE, rr pointer=0, burst count=0, timeout count=0.
- Output stage can load when `load_ok = !out_valid | out_ready`.
- `req_ready[i]` is combinational: high only when load_ok is true and i is the selected requester.
- Transfer from requester i happens when req_valid[i] & req_ready[i]. At the next edge:
  - out_data <= req_data slice i
  - grant_id <= i
  - out_valid <= 1
- Latency: 1 cycle from accept to out_valid. Throughput: 1 transaction per cycle while out_ready stays high.
- If out_ready=1 and nothing is accepted, out_valid <= 0.
- out_data and grant_id hold while out_valid=1 and out_ready=0.
- State IDLE (round-robin):
  - Select the first valid requester, searching from rr pointer upward with wrap (rr, rr+1 … NUM_REQ-1, 0 …).
  - On transfer, rr pointer <= (i+1) mod NUM_REQ.
  - If the transferred transaction has cmd[3]=1 and MAX_BURST>1: go to LOCKED, owner=i, burst count=1, timeout count=0.
- State LOCKED:
  - Only the owner may be selected; all other requesters are stalled.
  - On an owner transfer, burst count increments and timeout count clears.
  - Leave for IDLE when the transferred transaction has cmd[3]=0, or when burst count reaches MAX_BURST.
  - Each cycle with the owner's req_valid=0, timeout count increments. At LOCKED_TIMEOUT the arbiter returns to IDLE with no transfer that cycle.
  - The rr pointer is not updated while LOCKED; it is set to owner+1 on exit.
- locked = (state == LOCKED).
- Simultaneous events: draining out_data (out_ready) and loading a new transaction in the same cycle is legal and required (no bubble).
- Downstream stall: load_ok=0, so all req_ready=0. The arbitration decision is re-evaluated every cycle; no grant is latched early.
- Reset mid-operation: any held out_data is discarded, out_valid=0 on the next edge, and the lock is dropped.
- No field of the struct is modified by the arbiter, except as described under ARB_TAG_EN.

Optional Feature:
- Macro: NESTED_ARB_TAG_EN.
- When defined: out_data[56:53] (id[15:12]) is replaced by the granted requester index, zero-extended to 4 bits. All other bits pass through.
- When undefined: out_data is bit-identical to the accepted req_data slice.

Test Plan:
- Reset, then all req_valid=1, out_ready=1, cmd=0 → grants in order 0,1,2,3,0, one per cycle. out_valid is first high on the cycle after the first accept.
- req 2 sends cmd=4'h8 ×3 then cmd=4'h0, with reqs 0/1/3 also valid → grant_id=2 for 4 consecutive transfers, locked=1 during the burst, then grants 3,0,1.
- req 1 sends cmd=4'hF continuously, MAX_BURST=8 → exactly 8 consecutive grants to 1, then locked=0 and grant goes to 2.
- Lock by req 0, then req 0 drops valid while req 3 is valid → no grant for 16 cycles; grant to 3 on the cycle after the timeout.
- out_ready=0 for 5 cycles with out_data=62'h2AAA_BBBB_CCCC_DDDD → out_data stable, all req_ready=0; out_ready=1 → drain and new load in the same cycle.
- rst asserted while out_valid=1 and locked=1 → next cycle out_valid=0, locked=0, grant restarts at requester 0. With NESTED_ARB_TAG_EN, a grant to req 3 shows id[15:12]=4'h3.
